// File: rtl/mem_refill_arbiter.sv
// Refill arbiter: shares one word memory between the I-cache and D-cache
// miss handlers. A granted transaction runs an optional 16-word dirty
// writeback and then a 16-word block fill. Each burst is preceded by
// LATENCY wait cycles.
module mem_refill_arbiter #(
   parameter int unsigned LATENCY     = 4,   // 1..255
   parameter int unsigned ME_PRIORITY = 1    // 1: data side wins ties, 0: round-robin
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        if_req,
   input  logic [25:0] if_blk,
   input  logic        me_req,
   input  logic [25:0] me_blk,
   input  logic        me_dirty,
   input  logic [25:0] me_victim_blk,
   input  logic [31:0] me_wdata,
   output logic        if_grant,
   output logic        me_grant,
   output logic        if_done,
   output logic        me_done,
   output logic        fill_valid,
   output logic [3:0]  fill_idx,
   output logic [31:0] fill_data,
   output logic [3:0]  word_idx,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, WB_WAIT, WB, FILL_WAIT, FILL, DRAIN, DONE
   } state_t;

   localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

   state_t      state, state_nxt;
   logic        own_me;       // data side owns the current transaction
   logic        rr_last_me;   // winner of the most recent tie
   logic [25:0] blk_q;        // block being filled
   logic [25:0] victim_q;     // block being written back
   logic [7:0]  cnt;          // latency wait counter
   logic [3:0]  idx;          // burst word index
   logic        fill_vld_q;
   logic [3:0]  fill_idx_q;
   logic        any_req, tie, win_me;

   assign any_req = if_req | me_req;
   assign tie     = if_req & me_req;

   // Arbitration: fixed data-side priority or alternate on ties.
   always_comb begin
      win_me = me_req;
      if (tie) win_me = (ME_PRIORITY != 0) ? 1'b1 : ~rr_last_me;
   end

   // Next-state sequencing of one refill transaction.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (any_req) state_nxt = (win_me && me_dirty) ? WB_WAIT : FILL_WAIT;
         WB_WAIT:   if (cnt == LAT_LAST) state_nxt = WB;
         WB:        if (idx == 4'd15) state_nxt = FILL_WAIT;
         FILL_WAIT: if (cnt == LAT_LAST) state_nxt = FILL;
         FILL:      if (idx == 4'd15) state_nxt = DRAIN;
         DRAIN:     state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Strobes, addresses and handshake pulses decoded from the current state.
   always_comb begin
      if_grant  = 1'b0;
      me_grant  = 1'b0;
      if_done   = 1'b0;
      me_done   = 1'b0;
      word_idx  = '0;
      mem_addr  = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_wdata = '0;
      case (state)
         IDLE: if (any_req && resetn) begin
            // Gated by reset so every output is quiet while reset is held.
            me_grant = win_me;
            if_grant = ~win_me;
         end
         WB: begin
            word_idx  = idx;
            mem_wr    = 1'b1;
            mem_addr  = {victim_q, idx, 2'b00};
            mem_wdata = me_wdata;
         end
         FILL: begin
            mem_rd   = 1'b1;
            mem_addr = {blk_q, idx, 2'b00};
         end
         DONE: begin
            if_done = ~own_me;
            me_done = own_me;
         end
         default: ;
      endcase
   end

   // Read data returns one cycle after the strobe, so the fill index trails by one.
   assign fill_valid = fill_vld_q;
   assign fill_idx   = fill_idx_q;
   assign fill_data  = fill_vld_q ? mem_rdata : '0;

   // State, transaction latches, counters and the fill-return pipeline.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         own_me     <= 1'b0;
         rr_last_me <= 1'b0;
         blk_q      <= '0;
         victim_q   <= '0;
         cnt        <= '0;
         idx        <= '0;
         fill_vld_q <= 1'b0;
         fill_idx_q <= '0;
      end else begin
         state      <= state_nxt;
         fill_vld_q <= (state == FILL);
         fill_idx_q <= (state == FILL) ? idx : 4'd0;
         if (state == IDLE && any_req) begin
            own_me   <= win_me;
            blk_q    <= win_me ? me_blk : if_blk;
            victim_q <= me_victim_blk;
            if (tie) rr_last_me <= win_me;
         end
         // Counters only advance while the state holds; leaving it clears them.
         cnt <= (state_nxt == state && (state == WB_WAIT || state == FILL_WAIT)) ? cnt + 8'd1 : 8'd0;
         idx <= (state_nxt == state && (state == WB || state == FILL)) ? idx + 4'd1 : 4'd0;
      end
   end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares the single backing word memory between the instruction-cache and data-cache miss handlers.
- Arbitrates between the two refill requests and sequences the selected transaction: optional 16-word dirty writeback, then 16-word block fill, each burst preceded by a fixed access latency.
- Sits between both L1 caches (64-byte blocks, 16 words, direct-mapped, write-back) and the memory array.
- Caches hold their stall until the matching done pulse.

Parameters:
- LATENCY, 4, wait cycles before each burst (models the DRAM access delay); legal range 1..255.
- ME_PRIORITY, 1, 1 = data side always wins a tie; 0 = round-robin on ties (loser of the last tie wins the next).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- if_req  in  1  instruction-cache miss request; level, held until if_done.
- if_blk  in  26  instruction block address (addr[31:6]).
- me_req  in  1  data-cache miss request; level, held until me_done.
- me_blk  in  26  data block address to fill.
- me_dirty  in  1  victim line dirty; sampled at grant.
- me_victim_blk  in  26  victim block address (tag, index); sampled at grant.
- me_wdata  in  32  victim word selected by word_idx; combinational from the D-cache.
- if_grant, me_grant  out  1  one-cycle pulse in the grant cycle.
- if_done, me_done  out  1  one-cycle pulse; line is valid, requester may release its stall.
- fill_valid  out  1  fill_data/fill_idx valid; written by the currently owning cache.
- fill_idx  out  4  word index of fill_data.
- fill_data  out  32  refill word.
- word_idx  out  4  writeback word index presented to the D-cache.
- mem_addr  out  32  word-aligned byte address.
- mem_rd, mem_wr  out  1  memory read / write strobes.
- mem_wdata  out  32  equals me_wdata during writeback.
- mem_rdata  in  32  read data, valid one cycle after mem_rd.

Behaviour:
- Reset (async, any state): state goes to IDLE. All outputs are 0. Owner, round-robin pointer (points to IF) and counters are cleared. Any in-flight transaction is abandoned with no done pulse; requesters re-request after reset.
- States: IDLE, WB_WAIT, WB, FILL_WAIT, FILL, DRAIN, DONE.
- IDLE:
  - If any request is present, the granted side's grant pulses in this cycle, and owner, block address, dirty and victim are latched.
  - Next state is WB_WAIT if the ME side is granted with me_dirty=1; otherwise FILL_WAIT.
  - IF is never dirty.
  - Tie handling: ME_PRIORITY=1 gives ME. ME_PRIORITY=0 gives the side not granted at the previous tie. The pointer updates only on ties.
- WB_WAIT: counts LATENCY cycles, no memory strobes, then goes to WB.
- WB: 16 cycles with idx 0..15.
  - word_idx=idx, mem_wr=1, mem_addr={victim_blk, idx, 2'b00}, mem_wdata=me_wdata.
  - After idx 15, goes to FILL_WAIT.
- FILL_WAIT: counts LATENCY cycles, then goes to FILL.
- FILL: 16 cycles issuing mem_rd=1 with mem_addr={blk, idx, 2'b00}, idx 0..15.
- Fill data pipeline:
  - fill_valid=1, fill_idx=idx-1 and fill_data=mem_rdata one cycle after each read, i.e. fill_valid is high from the 2nd FILL cycle through DRAIN.
  - DRAIN is 1 cycle and delivers word 15.
- DONE: 1 cycle; owner's done=1, then IDLE.
  - A request still high in IDLE is a new miss and is arbitrated normally.
  - Requesters drop req the cycle after done.
- Latency from grant cycle (cycle 0) to done:
  - Clean: 1 + LATENCY + 16 + 1 cycles.
  - Dirty: 1 + 2·LATENCY + 32 + 1 cycles.
  - With LATENCY=4: clean done at cycle 22, dirty done at cycle 42.
- Request changes after grant are ignored: req deassert, address change or dirty change. The transaction always completes.
- The non-owner's request waits. It is never granted mid-transaction and is served in the next IDLE.
- mem_rd and mem_wr are never high together. mem_addr=0 when neither strobe is high.
- The counter and index wrap only through state exit. LATENCY=1 gives one wait cycle.

Test Plan:
- IF-only clean miss, if_blk=26'h000001 -> if_grant at t0; mem_rd addresses 0x40..0x7C; fill_idx 0..15 carry mem_rdata in order; if_done at t0+22; no mem_wr.
- ME dirty miss, me_victim_blk=26'h000010, me_blk=26'h000020 -> 16 mem_wr to 0x400..0x43C, data = me_wdata for word_idx 0..15; then reads 0x800..0x83C; me_done at t0+42.
- Simultaneous if_req and me_req, ME_PRIORITY=1 -> me_grant first; if_grant in the IDLE cycle after me_done. With ME_PRIORITY=0 over two successive ties -> ME then IF, then ME again on the third tie.
- if_req deasserted and if_blk changed during FILL -> fill still uses the latched address; if_done still pulses once.
- resetn low for 1 cycle mid-WB -> all outputs 0 immediately; no done pulse; a request re-asserted afterwards restarts from WB_WAIT (dirty) with a full sequence.
- LATENCY=1, back-to-back clean ME misses with req held -> second me_grant exactly 1 cycle after the first me_done; each done exactly 19 cycles after its grant.
